// File: rtl/decodificador_pwm_pkg.sv
// Purpose: shared FSM states and servo position codes for the PWM decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: estado_t (INICIAL/ALTO/BAIXO), POS_00..POS_11 position codes.
package decodificador_pwm_pkg;

  typedef enum logic [1:0] {
    INICIAL = 2'b00,  // waiting for the first rising edge
    ALTO    = 2'b01,  // line high, measuring pulse width
    BAIXO   = 2'b10   // line low, waiting for the next rising edge
  } estado_t;

  // Position codes shared with the servo controller side of the link.
  localparam logic [1:0] POS_00 = 2'b00;
  localparam logic [1:0] POS_01 = 2'b01;
  localparam logic [1:0] POS_10 = 2'b10;
  localparam logic [1:0] POS_11 = 2'b11;

endpackage

// File: rtl/decodificador_pwm_detector_borda.sv
// Purpose: synchronizes the asynchronous PWM line and flags its edges.
// Latency: sinal is pwm_in delayed 2 clocks; sub/desc valid 2 clocks after the edge.
// Backpressure: none, free-running.
// Ports: clock, reset (async active-low), entrada (async line),
//        sinal (synchronized level), sub (rising edge), desc (falling edge).
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic sinal,
  output logic sub,
  output logic desc
);

  // s1/s2 form the metastability synchronizer; s3 is one extra delay so
  // edges can be seen as a change between s3 and s2.
  logic s1, s2, s3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= entrada;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sinal = s2;
  assign sub   = s2 & ~s3;
  assign desc  = ~s2 & s3;

endmodule

// File: rtl/decodificador_pwm.sv
// Purpose: measures PWM high time and period and decodes width to a 2-bit servo position.
// Latency: outputs and pronto registered 3 clocks after pwm_in falls (sync + edge + register).
// Backpressure: none; pronto is a one-cycle strobe that is never held off.
// Ports: clock, reset (async active-low), pwm_in (async line), posicao, largura,
//        periodo, pronto (update strobe), erro (sticky bad width / stuck high), db_pwm.
module decodificador_pwm
  import decodificador_pwm_pkg::*;
#(
  parameter int CONF_PERIODO = 1000000,
  parameter int LARGURA_01   = 50000,
  parameter int LARGURA_10   = 75000,
  parameter int LARGURA_11   = 100000,
  parameter int TOLERANCIA   = 2500,
  parameter int TIMEOUT      = 2000000,
  parameter int N            = 21
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [1:0]   posicao,
  output logic [N-1:0] largura,
  output logic [N-1:0] periodo,
  output logic         pronto,
  output logic         erro,
  output logic         db_pwm
);

  // Counters must hold TIMEOUT, and a nominal period has to fit before timeout.
  if ((2 ** N) <= TIMEOUT || CONF_PERIODO >= TIMEOUT) begin : g_param_check
    $error("decodificador_pwm: N too small for TIMEOUT or CONF_PERIODO >= TIMEOUT");
  end

  localparam logic [N-1:0] LIMITE = N'(TIMEOUT);

  logic    sinal, sub, desc;
  estado_t estado;
  logic [N-1:0] cnt_alto, cnt_per;
  logic [N-1:0] cnt_alto_inc, cnt_per_inc;
  logic         per_sat;

  detector_borda u_detector_borda (
    .clock   (clock),
    .reset   (reset),
    .entrada (pwm_in),
    .sinal   (sinal),
    .sub     (sub),
    .desc    (desc)
  );

  assign db_pwm = sinal;

  // Saturating increments: counters stick at TIMEOUT instead of wrapping.
  assign cnt_alto_inc = (cnt_alto >= LIMITE) ? cnt_alto : cnt_alto + 1'b1;
  assign cnt_per_inc  = (cnt_per  >= LIMITE) ? cnt_per  : cnt_per  + 1'b1;
  assign per_sat      = (cnt_per >= LIMITE);

  // Inclusive window test |w - nominal| <= TOLERANCIA in N+1-bit signed math,
  // so widths below the nominal value give a negative difference, not a wrap.
  function automatic logic na_janela(input logic [N-1:0] w, input int nominal);
    logic signed [N:0] dif;
    dif = $signed({1'b0, w}) - $signed({1'b0, N'(nominal)});
    if (dif < 0) dif = -dif;
    return dif <= $signed((N+1)'(TOLERANCIA));
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= INICIAL;
      cnt_alto <= '0;
      cnt_per  <= '0;
      posicao  <= POS_00;
      largura  <= '0;
      periodo  <= '0;
      pronto   <= 1'b0;
      erro     <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        INICIAL: begin
          // First edge after reset/timeout only starts the counters; there is
          // no previous rise to measure a period against.
          if (sub) begin
            cnt_alto <= N'(1);
            cnt_per  <= N'(1);
            estado   <= ALTO;
          end
        end
        ALTO: begin
          if (desc) begin
            largura <= cnt_alto;
            pronto  <= 1'b1;
            cnt_per <= cnt_per_inc;
            estado  <= BAIXO;
            if (na_janela(cnt_alto, LARGURA_01)) begin
              posicao <= POS_01;
              erro    <= 1'b0;
            end else if (na_janela(cnt_alto, LARGURA_10)) begin
              posicao <= POS_10;
              erro    <= 1'b0;
            end else if (na_janela(cnt_alto, LARGURA_11)) begin
              posicao <= POS_11;
              erro    <= 1'b0;
            end else begin
              erro    <= 1'b1;  // position kept, width still reported
            end
          end else if (per_sat) begin
            // Line stuck high: flag it but keep the last good position.
            erro   <= 1'b1;
            pronto <= 1'b1;
            estado <= INICIAL;
          end else begin
            cnt_alto <= cnt_alto_inc;
            cnt_per  <= cnt_per_inc;
          end
        end
        BAIXO: begin
          if (sub) begin
            periodo  <= cnt_per;
            cnt_alto <= N'(1);
            cnt_per  <= N'(1);
            estado   <= ALTO;
          end else if (per_sat) begin
            // Line held low is a legitimate 0 ms pulse, i.e. code 00.
            posicao <= POS_00;
            largura <= '0;
            erro    <= 1'b0;
            pronto  <= 1'b1;
            estado  <= INICIAL;
          end else begin
            cnt_per <= cnt_per_inc;
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule

// File: tb/tb_decodificador_pwm.sv
module tb_decodificador_pwm;

  localparam int N       = 21;
  localparam int TIMEOUT = 2000;
  localparam int TOL     = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         pwm_in = 1'b0;
  logic [1:0]   posicao;
  logic [N-1:0] largura, periodo;
  logic         pronto, erro, db_pwm;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct packed {
    logic [1:0]   pos;
    logic [N-1:0] lar;
    logic         err;
    logic [N-1:0] per;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  // Reference state: what the receiver should currently be reporting.
  int   m_pos = 0, m_lar = 0, m_per = 0, last_rise = -1;
  logic m_err = 1'b0;

  decodificador_pwm #(
    .CONF_PERIODO (1000),
    .LARGURA_01   (50),
    .LARGURA_10   (75),
    .LARGURA_11   (100),
    .TOLERANCIA   (TOL),
    .TIMEOUT      (TIMEOUT),
    .N            (N)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .pwm_in  (pwm_in),
    .posicao (posicao),
    .largura (largura),
    .periodo (periodo),
    .pronto  (pronto),
    .erro    (erro),
    .db_pwm  (db_pwm)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(negedge clock)
    if (pronto) obs_q.push_back('{pos: posicao, lar: largura, err: erro, per: periodo});

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk_ev();
    ev_t e;
    e.pos = 2'(m_pos);
    e.lar = N'(m_lar);
    e.err = m_err;
    e.per = N'(m_per);
    return e;
  endfunction

  // Line silent for more than TIMEOUT clocks since the last rise: code 00 report.
  task automatic model_idle();
    if (last_rise >= 0 && cyc - last_rise > TIMEOUT) begin
      m_pos = 0; m_lar = 0; m_err = 1'b0;
      exp_q.push_back(mk_ev());
      last_rise = -1;
    end
  endtask

  task automatic model_rise();
    model_idle();
    if (last_rise >= 0) m_per = cyc - last_rise;
    last_rise = cyc;
  endtask

  task automatic model_fall(input int w);
    int nom[3] = '{50, 75, 100};
    int d;
    logic hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = w - nom[k];
      if (d < 0) d = -d;
      if (!hit && d <= TOL) begin
        m_pos = k + 1;
        hit = 1'b1;
      end
    end
    m_lar = w;
    m_err = !hit;
    exp_q.push_back(mk_ev());
  endtask

  task automatic drive_pulse(input int h, input int p);
    model_rise();
    pwm_in = 1'b1;
    repeat (h) @(posedge clock);
    #1 pwm_in = 1'b0;
    model_fall(h);
    repeat (p - h) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; pwm_in = 1'b0;
    #5;
    tests += 6;
    if (posicao !== 2'b00) begin fails++; $display("FAIL reset posicao: got %0d want 0", posicao); end
    if (largura !== '0)    begin fails++; $display("FAIL reset largura: got %0d want 0", largura); end
    if (periodo !== '0)    begin fails++; $display("FAIL reset periodo: got %0d want 0", periodo); end
    if (pronto !== 1'b0)   begin fails++; $display("FAIL reset pronto: got %0b want 0", pronto); end
    if (erro !== 1'b0)     begin fails++; $display("FAIL reset erro: got %0b want 0", erro); end
    if (db_pwm !== 1'b0)   begin fails++; $display("FAIL reset db_pwm: got %0b want 0", db_pwm); end
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 3; i++) drive_pulse(75, 1000);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL nominal count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL nominal ev%0d: got pos=%0d lar=%0d err=%0b per=%0d want pos=%0d lar=%0d err=%0b per=%0d", i, obs_q[i].pos, obs_q[i].lar, obs_q[i].err, obs_q[i].per, exp_q[i].pos, exp_q[i].lar, exp_q[i].err, exp_q[i].per); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_latency();
    int k = 0;
    model_rise();
    pwm_in = 1'b1;
    repeat (75) @(posedge clock);
    #1 pwm_in = 1'b0;
    model_fall(75);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      if (k == 0 && pronto) k = i;
    end
    tests++;
    if (k < 2 || k > 4) begin fails++; $display("FAIL latency: pronto after %0d edges want 2..4", k); end
    repeat (200) @(posedge clock);
    #1;
    tests++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      fails++; $display("FAIL latency ev: got %0d events lar=%0d want 1 event lar=75", obs_q.size(), largura);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_windows();
    int ws[5] = '{44, 45, 55, 56, 1};
    foreach (ws[i]) drive_pulse(ws[i], 300);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL windows count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL windows w=%0d: got pos=%0d lar=%0d err=%0b per=%0d want pos=%0d lar=%0d err=%0b per=%0d", ws[i], obs_q[i].pos, obs_q[i].lar, obs_q[i].err, obs_q[i].per, exp_q[i].pos, exp_q[i].lar, exp_q[i].err, exp_q[i].per); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_idle_low();
    int r;
    drive_pulse(100, 300);
    r = last_rise;
    while (cyc < r + TIMEOUT - 10) @(posedge clock);
    #1;
    tests++;
    if (obs_q.size() !== 1) begin fails++; $display("FAIL idle early: got %0d events before timeout want 1", obs_q.size()); end
    while (cyc < r + TIMEOUT + 10) @(posedge clock);
    #1;
    model_idle();
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL idle count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL idle ev%0d: got pos=%0d lar=%0d err=%0b per=%0d want pos=%0d lar=%0d err=%0b per=%0d", i, obs_q[i].pos, obs_q[i].lar, obs_q[i].err, obs_q[i].per, exp_q[i].pos, exp_q[i].lar, exp_q[i].err, exp_q[i].per); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stuck_high();
    drive_pulse(75, 300);
    model_rise();
    pwm_in = 1'b1;
    repeat (TIMEOUT + 100) @(posedge clock);
    #1;
    // Stuck high: error flagged, last position and width retained.
    m_err = 1'b1;
    exp_q.push_back(mk_ev());
    last_rise = -1;
    pwm_in = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    drive_pulse(50, 300);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL stuck count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL stuck ev%0d: got pos=%0d lar=%0d err=%0b per=%0d want pos=%0d lar=%0d err=%0b per=%0d", i, obs_q[i].pos, obs_q[i].lar, obs_q[i].err, obs_q[i].per, exp_q[i].pos, exp_q[i].lar, exp_q[i].err, exp_q[i].per); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_pulse();
    drive_pulse(100, 300);
    pwm_in = 1'b1;
    repeat (42) @(posedge clock);
    #5 reset = 1'b0;
    #1;
    tests += 4;
    if (posicao !== 2'b00) begin fails++; $display("FAIL midreset posicao: got %0d want 0", posicao); end
    if (largura !== '0)    begin fails++; $display("FAIL midreset largura: got %0d want 0", largura); end
    if (periodo !== '0)    begin fails++; $display("FAIL midreset periodo: got %0d want 0", periodo); end
    if (db_pwm !== 1'b0)   begin fails++; $display("FAIL midreset db_pwm: got %0b want 0", db_pwm); end
    pwm_in = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    m_pos = 0; m_lar = 0; m_per = 0; m_err = 1'b0; last_rise = -1;
    exp_q.delete(); obs_q.delete();
    repeat (5) @(posedge clock);
    #1;
    drive_pulse(100, 300);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL midreset count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL midreset ev%0d: got pos=%0d lar=%0d err=%0b per=%0d want pos=%0d lar=%0d err=%0b per=%0d", i, obs_q[i].pos, obs_q[i].lar, obs_q[i].err, obs_q[i].per, exp_q[i].pos, exp_q[i].lar, exp_q[i].err, exp_q[i].per); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int nom[3] = '{50, 75, 100};
    int w, p;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) w = $urandom_range(1, 150);
      else w = nom[$urandom_range(0, 2)] + $urandom_range(0, 16) - 8;
      p = w + $urandom_range(50, 300);
      drive_pulse(w, p);
    end
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL random ev%0d: got pos=%0d lar=%0d err=%0b per=%0d want pos=%0d lar=%0d err=%0b per=%0d", i, obs_q[i].pos, obs_q[i].lar, obs_q[i].err, obs_q[i].per, exp_q[i].pos, exp_q[i].lar, exp_q[i].err, exp_q[i].per); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  // Servo-side emulation: nominal pulses for each code, decoded within two periods.
  task automatic test_loopback();
    int nom[3] = '{50, 75, 100};
    for (int c = 1; c <= 3; c++) begin
      drive_pulse(nom[c-1], 1000);
      drive_pulse(nom[c-1], 1000);
      tests += 2;
      if (posicao !== 2'(c)) begin fails++; $display("FAIL loopback code %0d: got posicao=%0d", c, posicao); end
      if (obs_q.size() !== exp_q.size() || obs_q.size() == 0 || obs_q[obs_q.size()-1] !== exp_q[exp_q.size()-1]) begin
        fails++; $display("FAIL loopback ev code %0d: got %0d events lar=%0d want %0d events lar=%0d", c, obs_q.size(), largura, exp_q.size(), nom[c-1]);
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_latency();
    test_windows();
    test_idle_low();
    test_stuck_high();
    test_reset_mid_pulse();
    test_random();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
